// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
//
// APB master stage. Takes read/write commands on a valid/ready port and runs
// each one as an APB SETUP -> ACCESS transfer. One command can be held in a
// pending slot so back-to-back transfers run without an IDLE cycle between
// them. Every completion produces a one-cycle response pulse; a slave error or
// a wait-state timeout sets rsp_err.
//
// Ports
//   pclk, preset_n          clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready   command handshake
//   cmd_write, cmd_addr,    command payload (1 = write)
//   cmd_wdata
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata               read data (0 for writes and timeouts)
//   rsp_err                 pslave_error or timeout
//   rsp_timeout             completion forced by the wait-state timeout
//   pselx, penable, pwrite, APB requester outputs (all registered)
//   paddr, pwdata
//   prdata, pready,         APB completer inputs
//   pslave_error
//   fsm_state               debug view of the FSM (0 IDLE, 1 SETUP, 2 ACCESS)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on reset and the pending
// slot, never on cmd_valid, and the payload is sampled on that same edge.
// -----------------------------------------------------------------------------
module apb_requester #(
    parameter int addr_width = 8,
    parameter int data_width = 8,
    parameter int timeout    = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [data_width-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [addr_width-1:0] paddr,
    output logic [data_width-1:0] pwdata,
    input  logic [data_width-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslave_error,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Wait counter is sized to hold the timeout value; at least 1 bit when
    // the timeout is disabled.
    localparam int cnt_w = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam bit to_en = (timeout != 0);
    localparam int to_last = (timeout > 0) ? (timeout - 1) : 0;
    localparam logic [cnt_w-1:0] cnt_last = to_last[cnt_w-1:0];
    localparam logic [cnt_w-1:0] cnt_max  = '1;

    state_t                state, state_nx;
    logic [cnt_w-1:0]      wait_cnt, cnt_nx;

    logic                  pend_valid;
    logic                  pend_write;
    logic [addr_width-1:0] pend_addr;
    logic [data_width-1:0] pend_wdata;

    logic                  accept;
    logic                  load_cmd;
    logic                  load_pend;
    logic                  pend_set;
    logic                  pend_clr;
    logic                  done_ok;
    logic                  done_to;

    assign cmd_ready = preset_n && !pend_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign fsm_state = state;

    always_comb begin
        state_nx  = state;
        cnt_nx    = wait_cnt;
        load_cmd  = 1'b0;
        load_pend = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load_cmd = 1'b1;
                    state_nx = ST_SETUP;
                end
            end

            ST_SETUP: begin
                state_nx = ST_ACCESS;
                if (accept) begin
                    pend_set = 1'b1;
                end
            end

            ST_ACCESS: begin
                // pready has priority over an expiring timeout.
                if (pready) begin
                    done_ok = 1'b1;
                end else if (to_en && (wait_cnt == cnt_last)) begin
                    done_to = 1'b1;
                end else if (wait_cnt != cnt_max) begin
                    cnt_nx = wait_cnt + 1'b1;
                end

                if (done_ok || done_to) begin
                    cnt_nx = '0;
                    // Pending command first, then a command arriving on this
                    // edge goes straight to the active registers.
                    if (pend_valid) begin
                        load_pend = 1'b1;
                        pend_clr  = 1'b1;
                        state_nx  = ST_SETUP;
                    end else if (accept) begin
                        load_cmd = 1'b1;
                        state_nx = ST_SETUP;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else if (accept) begin
                    pend_set = 1'b1;
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            pend_valid  <= 1'b0;
            pend_write  <= 1'b0;
            pend_addr   <= '0;
            pend_wdata  <= '0;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= cnt_nx;
            pselx    <= (state_nx != ST_IDLE);
            penable  <= (state_nx == ST_ACCESS);

            // pwdata is only touched by writes so it keeps the last write
            // value across reads and idle periods.
            if (load_cmd) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                if (cmd_write) begin
                    pwdata <= cmd_wdata;
                end
            end else if (load_pend) begin
                paddr  <= pend_addr;
                pwrite <= pend_write;
                if (pend_write) begin
                    pwdata <= pend_wdata;
                end
            end

            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_write <= cmd_write;
                pend_addr  <= cmd_addr;
                pend_wdata <= cmd_wdata;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end

            rsp_valid   <= done_ok || done_to;
            rsp_err     <= done_to || (done_ok && pslave_error);
            rsp_timeout <= done_to;
            rsp_rdata   <= (done_ok && !pwrite) ? prdata : '0;
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_apb_requester
//
// Directed bench for apb_requester (timeout = 4). Stimulus tasks push the
// expected response (arrival cycle, rdata, err, timeout) into exp_q; a
// monitor pops and compares whenever rsp_valid is seen. Per-cycle history of
// pselx / penable / cmd_ready is recorded for bus-timing checks.
// Cycle numbering: cyc counts rising edges; a command "accepted in cycle k"
// is presented with cmd_ready high while cyc == k.
// -----------------------------------------------------------------------------
module tb_apb_requester;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int EW = 32 + DW + 2;
    localparam int HN = 2048;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslave_error = 1'b0;
    logic [1:0]    fsm_state;

    apb_requester #(
        .addr_width(AW),
        .data_width(DW),
        .timeout   (4)
    ) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .pselx       (pselx),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslave_error(pslave_error),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 pclk = ~pclk;

    logic [31:0] cyc = '0;
    always @(posedge pclk) cyc <= cyc + 1;

    // ---------------- counters / scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    int rsp_count = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    logic hist_psel [0:HN-1];
    logic hist_pen  [0:HN-1];
    logic hist_rdy  [0:HN-1];

    // ---------------- completer model ----------------
    int   slave_waits = 0;
    bit   slave_stuck = 0;
    logic [DW-1:0] slave_rdata = '0;
    logic slave_err = 1'b0;
    int   wcnt = 0;

    always @(negedge pclk) begin
        if (pselx && penable && !slave_stuck) begin
            if (wcnt == slave_waits) begin
                pready       = 1'b1;
                prdata       = slave_rdata;
                pslave_error = slave_err;
                wcnt         = 0;
            end else begin
                pready       = 1'b0;
                pslave_error = 1'b0;
                wcnt         = wcnt + 1;
            end
        end else begin
            pready       = 1'b0;
            pslave_error = 1'b0;
            wcnt         = 0;
        end
    end

    // ---------------- history + monitor ----------------
    always @(negedge pclk) begin
        if (cyc < HN) begin
            hist_psel[cyc] = pselx;
            hist_pen[cyc]  = penable;
            hist_rdy[cyc]  = cmd_ready;
        end
    end

    always @(negedge pclk) begin
        if (rsp_valid) begin
            rsp_count = rsp_count + 1;
            n_vec     = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected_rsp: cyc=%0d rdata=%h err=%b timeout=%b, no response expected",
                         cyc, rsp_rdata, rsp_err, rsp_timeout);
            end else begin
                mon_e = exp_q.pop_front();
                if ({cyc, rsp_rdata, rsp_err, rsp_timeout} !== mon_e) begin
                    n_bad = n_bad + 1;
                    $display("FAIL rsp: got cyc=%0d rdata=%h err=%b timeout=%b, expected cyc=%0d rdata=%h err=%b timeout=%b",
                             cyc, rsp_rdata, rsp_err, rsp_timeout,
                             mon_e[EW-1 -: 32], mon_e[DW+1:2], mon_e[1], mon_e[0]);
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] c, input logic [DW-1:0] rd,
                            input logic e, input logic to);
        exp_q.push_back({c, rd, e, to});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    // with k = cycle in which the handshake was presented.
    task automatic send(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int k);
        bit ok;
        ok        = 0;
        k         = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (cmd_ready) begin
                ok = 1;
                k  = int'(cyc);
            end
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL send_accept: cmd_ready never high for addr %h", a);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, pselx, penable, pwrite, paddr, pwdata, rsp_valid,
                rsp_rdata, rsp_err, rsp_timeout, cmd_ready};
    endfunction

    function automatic logic [31:0] bus_view();
        return {13'd0, pselx, penable, pwrite, paddr, pwdata};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int k, ka, kb, kc, rc;
        preset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        // Reset state
        wait_cycles(3);
        check("reset_outputs", all_outs(), 32'd0);
        check("reset_state", {30'd0, fsm_state}, 32'd0);
        preset_n = 1'b1;
        wait_cycles(1);
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Write 0x3 <- 0xA5, zero waits; prdata nonzero must not leak
        slave_waits = 0;
        slave_rdata = 8'hFF;
        send(1'b1, 8'h03, 8'hA5, k);
        push_exp(k + 3, 8'h00, 1'b0, 1'b0);
        check("wr_setup_bus", bus_view(), {13'd0, 1'b1, 1'b0, 1'b1, 8'h03, 8'hA5});
        wait_cycles(4);
        check("wr_psel_pen_timing",
              {28'd0, hist_psel[k], hist_psel[k+1], hist_pen[k+1], hist_pen[k+2]},
              32'b0101);

        // Read 0x3 with 2 wait states; pwdata keeps last write value
        slave_waits = 2;
        slave_rdata = 8'hA5;
        send(1'b0, 8'h03, 8'h5E, k);
        push_exp(k + 5, 8'hA5, 1'b0, 1'b0);
        check("rd_setup_bus", bus_view(), {13'd0, 1'b1, 1'b0, 1'b0, 8'h03, 8'hA5});
        wait_cycles(6);

        // Three back-to-back commands with cmd_valid held high
        slave_waits = 0;
        slave_rdata = 8'h5A;
        send(1'b1, 8'h10, 8'h11, ka);
        push_exp(ka + 3, 8'h00, 1'b0, 1'b0);
        send(1'b0, 8'h20, 8'h22, kb);
        push_exp(ka + 5, 8'h5A, 1'b0, 1'b0);
        send(1'b1, 8'h30, 8'h33, kc);
        push_exp(ka + 7, 8'h00, 1'b0, 1'b0);
        check("b2b_accept_gap_b", kb - ka, 32'd1);
        check("b2b_accept_gap_c", kc - ka, 32'd3);
        wait_cycles(6);
        check("b2b_psel_held",
              {25'd0, hist_psel[ka+1], hist_psel[ka+2], hist_psel[ka+3], hist_psel[ka+4],
               hist_psel[ka+5], hist_psel[ka+6], hist_psel[ka+7]},
              32'b1111110);
        check("b2b_pen_toggle",
              {26'd0, hist_pen[ka+1], hist_pen[ka+2], hist_pen[ka+3],
               hist_pen[ka+4], hist_pen[ka+5], hist_pen[ka+6]},
              32'b010101);
        check("b2b_ready_drop",
              {27'd0, hist_rdy[ka+1], hist_rdy[ka+2], hist_rdy[ka+3],
               hist_rdy[ka+4], hist_rdy[ka+5]},
              32'b10101);
        check("b2b_last_write_data", {24'd0, pwdata}, 32'h33);

        // Timeout: pready stuck low, ACCESS lasts exactly 4 cycles
        slave_stuck = 1;
        send(1'b0, 8'h44, 8'h00, k);
        push_exp(k + 6, 8'h00, 1'b1, 1'b1);
        wait_cycles(8);
        check("to_pen_window",
              {26'd0, hist_pen[k+1], hist_pen[k+2], hist_pen[k+3],
               hist_pen[k+4], hist_pen[k+5], hist_pen[k+6]},
              32'b011110);
        check("to_back_to_idle", {29'd0, hist_psel[k+6], fsm_state}, 32'd0);
        slave_stuck = 0;

        // pready arrives on the expiry cycle: normal completion wins
        slave_waits = 3;
        slave_rdata = 8'hC3;
        send(1'b0, 8'h55, 8'h00, k);
        push_exp(k + 6, 8'hC3, 1'b0, 1'b0);
        wait_cycles(7);

        // Slave error with pready on a read
        slave_waits = 0;
        slave_err   = 1'b1;
        slave_rdata = 8'h3C;
        send(1'b0, 8'h66, 8'h00, k);
        push_exp(k + 3, 8'h3C, 1'b1, 1'b0);
        wait_cycles(4);
        slave_err = 1'b0;

        // Reset during ACCESS with a command pending
        slave_stuck = 1;
        send(1'b1, 8'h77, 8'h99, ka);
        send(1'b0, 8'h78, 8'h00, kb);
        check("rst_pend_accept", kb - ka, 32'd1);
        check("rst_pre_state", {30'd0, penable, cmd_ready}, 32'b10);
        rc = rsp_count;
        preset_n = 1'b0;
        #1;
        check("rst_async_outputs", all_outs(), 32'd0);
        wait_cycles(2);
        preset_n = 1'b1;
        #1;
        check("rst_release_ready", {29'd0, cmd_ready, fsm_state}, 32'b100);
        slave_stuck = 0;
        wait_cycles(10);
        check("rst_no_response", rsp_count - rc, 32'd0);
        check("rst_pwdata_cleared", {24'd0, pwdata}, 32'h00);
        send(1'b1, 8'h12, 8'h34, k);
        push_exp(k + 3, 8'h00, 1'b0, 1'b0);
        check("post_rst_setup_bus", bus_view(), {13'd0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34});
        check("post_rst_from_idle", {31'd0, hist_psel[k]}, 32'd0);

        // Drain
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge pclk);
        wait_cycles(3);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
